// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/interlock scoreboard: stage entry layout,
// forward-select encoding and the decode opcode classes.
package fwd_pkg;

    localparam int FWD_RF = 0;

    typedef enum logic [1:0] {
        OP_ALU  = 2'd0,
        OP_LOAD = 2'd1,
        OP_MC   = 2'd2
    } op_class_t;

    // Destination index travels beside the entry so the struct stays width-independent
    typedef struct packed {
        logic      valid;
        logic      wr;
        op_class_t cls;
    } stage_entry_t;

    function automatic op_class_t classify(input logic is_load, input logic is_mc);
        if (is_mc)
            return OP_MC;
        else if (is_load)
            return OP_LOAD;
        return OP_ALU;
    endfunction

    function automatic logic stage_ready(input op_class_t cls, input int stage,
                                         input int load_stage);
        case (cls)
            OP_ALU:  return 1'b1;
            OP_LOAD: return (stage >= load_stage);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fwd_port_match.sv
// Priority match of one source operand against the in-flight producer stages;
// the youngest live producer decides between forwarding and a RAW stall.
module fwd_port_match
    import fwd_pkg::*;
#(
    parameter int REGFILE_LEN      = 6,
    parameter int NUM_STAGES       = 3,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_WIDTH        = 2
) (
    input  logic [REGFILE_LEN-1:0]                  rs_i,
    input  logic                                    used_i,
    input  stage_entry_t [NUM_STAGES-1:0]           ent_i,
    input  logic [NUM_STAGES-1:0][REGFILE_LEN-1:0]  rd_i,
    output logic [SEL_WIDTH-1:0]                    sel_o,
    output logic                                    raw_stall_o
);

    logic                 hit;
    logic                 hit_ready;
    logic [SEL_WIDTH-1:0] hit_sel;

    always_comb begin
        hit       = 1'b0;
        hit_ready = 1'b0;
        hit_sel   = '0;
        // Walk oldest to youngest so the lowest matching stage overwrites
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (ent_i[k].valid && ent_i[k].wr && (rd_i[k] != '0) && (rd_i[k] == rs_i)) begin
                hit       = 1'b1;
                hit_sel   = SEL_WIDTH'(k + 1);
                hit_ready = stage_ready(ent_i[k].cls, k, LOAD_READY_STAGE);
            end
        end
    end

    always_comb begin
        sel_o       = SEL_WIDTH'(FWD_RF);
        raw_stall_o = 1'b0;
        if (used_i && (rs_i != '0) && hit) begin
            if (hit_ready)
                sel_o = hit_sel;
            else
                raw_stall_o = 1'b1;
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Decode-side forwarding and interlock unit: shadows in-flight destinations per
// stage, tracks multi-cycle results in a pending bitmap, drives fwd_sel and stall.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int REGFILE_LEN      = 6,
    parameter int NUM_STAGES       = 3,
    parameter int NUM_READ_PORTS   = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_WIDTH        = $clog2(NUM_STAGES + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  hold,
    input  logic                                  flush,
    input  logic                                  issue_valid,
    input  logic [REGFILE_LEN-1:0]                issue_rd,
    input  logic                                  issue_reg_write,
    input  logic                                  issue_is_load,
    input  logic                                  issue_is_mc,
    input  logic [NUM_READ_PORTS*REGFILE_LEN-1:0] rs_ids,
    input  logic [NUM_READ_PORTS-1:0]             rs_used,
    input  logic                                  mc_done,
    input  logic [REGFILE_LEN-1:0]                mc_rd,
    output logic [NUM_READ_PORTS*SEL_WIDTH-1:0]   fwd_sel,
    output logic                                  stall
);

    localparam int NUM_REGS = 1 << REGFILE_LEN;

    stage_entry_t [NUM_STAGES-1:0]          ent_q, ent_d, ent_src;
    logic [NUM_STAGES-1:0][REGFILE_LEN-1:0] rd_q, rd_d;
    logic [NUM_REGS-1:0]                    pend_q, pend_d;

    logic [NUM_READ_PORTS-1:0] raw_stall;
    logic [NUM_READ_PORTS-1:0] pend_hit;
    logic                      waw;
    logic                      mc_busy;
    logic                      issue_fire;
    logic                      kill_mc;

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
        logic [REGFILE_LEN-1:0] rs;
        assign rs = rs_ids[p*REGFILE_LEN +: REGFILE_LEN];

        fwd_port_match #(
            .REGFILE_LEN      (REGFILE_LEN),
            .NUM_STAGES       (NUM_STAGES),
            .LOAD_READY_STAGE (LOAD_READY_STAGE),
            .SEL_WIDTH        (SEL_WIDTH)
        ) u_match (
            .rs_i        (rs),
            .used_i      (rs_used[p]),
            .ent_i       (ent_q),
            .rd_i        (rd_q),
            .sel_o       (fwd_sel[p*SEL_WIDTH +: SEL_WIDTH]),
            .raw_stall_o (raw_stall[p])
        );

        assign pend_hit[p] = rs_used[p] && (rs != '0) && pend_q[rs];
    end

    always_comb begin
        waw     = issue_reg_write && pend_q[issue_rd];
        mc_busy = issue_is_mc && (|pend_q);
        stall   = issue_valid && !flush &&
                  ((|raw_stall) || (|pend_hit) || waw || mc_busy);
    end

    assign issue_fire = issue_valid && !stall && !flush;
    assign kill_mc    = flush && ent_q[0].valid && (ent_q[0].cls == OP_MC);

    // Flush kills the stage-0 entry whether or not the pipe is advancing
    always_comb begin
        ent_src = ent_q;
        if (flush)
            ent_src[0].valid = 1'b0;
    end

    always_comb begin
        ent_d  = ent_src;
        rd_d   = rd_q;
        pend_d = pend_q;
        if (!hold) begin
            for (int k = NUM_STAGES - 1; k >= 1; k--) begin
                ent_d[k] = ent_src[k-1];
                rd_d[k]  = rd_q[k-1];
            end
            ent_d[0].valid = issue_fire;
            ent_d[0].wr    = issue_reg_write;
            ent_d[0].cls   = classify(issue_is_load, issue_is_mc);
            rd_d[0]        = issue_rd;
        end
        if (mc_done)
            pend_d[mc_rd] = 1'b0;
        if (kill_mc)
            pend_d[rd_q[0]] = 1'b0;
        // A new set is applied last so it wins over a same-register clear
        if (!hold && issue_fire && issue_is_mc && (issue_rd != '0))
            pend_d[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q  <= '0;
            rd_q   <= '0;
            pend_q <= '0;
        end else begin
            ent_q  <= ent_d;
            rd_q   <= rd_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard with default parameters: one task per scenario,
// hand-computed expectations for fwd_sel and stall.
module tb_fwd_scoreboard;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        flush;
    logic        issue_valid;
    logic [5:0]  issue_rd;
    logic        issue_reg_write;
    logic        issue_is_load;
    logic        issue_is_mc;
    logic [11:0] rs_ids;
    logic [1:0]  rs_used;
    logic        mc_done;
    logic [5:0]  mc_rd;
    logic [3:0]  fwd_sel;
    logic        stall;

    int n_pass;
    int n_total;

    fwd_scoreboard dut (
        .clk             (clk),
        .rst             (rst),
        .hold            (hold),
        .flush           (flush),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_reg_write (issue_reg_write),
        .issue_is_load   (issue_is_load),
        .issue_is_mc     (issue_is_mc),
        .rs_ids          (rs_ids),
        .rs_used         (rs_used),
        .mc_done         (mc_done),
        .mc_rd           (mc_rd),
        .fwd_sel         (fwd_sel),
        .stall           (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [5:0] rd, input logic wr,
                         input logic ld, input logic mc, input logic [5:0] r0,
                         input logic [5:0] r1, input logic [1:0] used);
        issue_valid     = v;
        issue_rd        = rd;
        issue_reg_write = wr;
        issue_is_load   = ld;
        issue_is_mc     = mc;
        rs_ids          = {r1, r0};
        rs_used         = used;
        #1;
    endtask

    task automatic idle;
        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00);
    endtask

    task automatic drain;
        idle();
        repeat (3) tick();
    endtask

    task automatic test_reset;
        rst = 1'b1; hold = 1'b0; flush = 1'b0; mc_done = 1'b0; mc_rd = '0;
        idle();
        tick(); tick();
        rst = 1'b0;
        #1;
        n_total++;
        if (fwd_sel !== 4'b0000) $display("FAIL reset_sel: got %b expected 0000", fwd_sel);
        else n_pass++;
        n_total++;
        if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall);
        else n_pass++;
        drive(1'b1, 6'd6, 1'b1, 1'b0, 1'b0, 6'd5, 6'd5, 2'b11);
        n_total++;
        if (fwd_sel !== 4'b0000 || stall !== 1'b0)
            $display("FAIL reset_reader: got sel=%b stall=%b expected 0000/0", fwd_sel, stall);
        else n_pass++;
        idle();
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00);
        n_total++;
        if (stall !== 1'b0) $display("FAIL b2b_add_stall: got %b expected 0", stall);
        else n_pass++;
        tick();
        drive(1'b1, 6'd6, 1'b1, 1'b0, 1'b0, 6'd5, 6'd0, 2'b01);
        n_total++;
        if (fwd_sel !== 4'b0001 || stall !== 1'b0)
            $display("FAIL b2b_sub: got sel=%b stall=%b expected 0001/0", fwd_sel, stall);
        else n_pass++;
        tick();
        drive(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd5, 2'b10);
        n_total++;
        if (fwd_sel !== 4'b1000 || stall !== 1'b0)
            $display("FAIL b2b_stage1: got sel=%b stall=%b expected 1000/0", fwd_sel, stall);
        else n_pass++;
        drain();
    endtask

    task automatic test_load_use;
        drive(1'b1, 6'd7, 1'b1, 1'b1, 1'b0, 6'd0, 6'd0, 2'b00);
        tick();
        drive(1'b1, 6'd8, 1'b1, 1'b0, 1'b0, 6'd7, 6'd0, 2'b01);
        n_total++;
        if (stall !== 1'b1 || fwd_sel !== 4'b0000)
            $display("FAIL lu_stall1: got sel=%b stall=%b expected 0000/1", fwd_sel, stall);
        else n_pass++;
        tick();
        n_total++;
        if (stall !== 1'b1) $display("FAIL lu_stall2: got %b expected 1", stall);
        else n_pass++;
        n_total++;
        if (dut.ent_q[0].valid !== 1'b0) $display("FAIL lu_bubble1: got %b expected 0", dut.ent_q[0].valid);
        else n_pass++;
        tick();
        n_total++;
        if (stall !== 1'b0 || fwd_sel !== 4'b0011)
            $display("FAIL lu_fwd: got sel=%b stall=%b expected 0011/0", fwd_sel, stall);
        else n_pass++;
        n_total++;
        if (dut.ent_q[0].valid !== 1'b0) $display("FAIL lu_bubble2: got %b expected 0", dut.ent_q[0].valid);
        else n_pass++;
        tick();
        drain();
    endtask

    task automatic test_x0_unused;
        drive(1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00);
        tick();
        drive(1'b1, 6'd4, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 2'b01);
        n_total++;
        if (fwd_sel !== 4'b0000 || stall !== 1'b0)
            $display("FAIL x0_read: got sel=%b stall=%b expected 0000/0", fwd_sel, stall);
        else n_pass++;
        tick();
        drive(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 6'd4, 6'd4, 2'b00);
        n_total++;
        if (fwd_sel !== 4'b0000 || stall !== 1'b0)
            $display("FAIL unused_port: got sel=%b stall=%b expected 0000/0", fwd_sel, stall);
        else n_pass++;
        drive(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd4, 2'b10);
        n_total++;
        if (fwd_sel !== 4'b0100 || stall !== 1'b0)
            $display("FAIL used_port_ref: got sel=%b stall=%b expected 0100/0", fwd_sel, stall);
        else n_pass++;
        drain();
    endtask

    task automatic test_multicycle;
        drive(1'b1, 6'd9, 1'b1, 1'b0, 1'b1, 6'd0, 6'd0, 2'b00);
        n_total++;
        if (stall !== 1'b0) $display("FAIL mc_issue: got %b expected 0", stall);
        else n_pass++;
        tick();
        drive(1'b1, 6'd11, 1'b1, 1'b0, 1'b0, 6'd9, 6'd0, 2'b01);
        n_total++;
        if (stall !== 1'b1) $display("FAIL mc_reader_c1: got %b expected 1", stall);
        else n_pass++;
        tick();
        drive(1'b1, 6'd12, 1'b1, 1'b0, 1'b1, 6'd0, 6'd0, 2'b00);
        n_total++;
        if (stall !== 1'b1) $display("FAIL mc_second_div: got %b expected 1", stall);
        else n_pass++;
        drive(1'b1, 6'd9, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00);
        n_total++;
        if (stall !== 1'b1) $display("FAIL mc_waw: got %b expected 1", stall);
        else n_pass++;
        drive(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 6'd20, 6'd0, 2'b01);
        n_total++;
        if (stall !== 1'b0) $display("FAIL mc_unrelated: got %b expected 0", stall);
        else n_pass++;
        drive(1'b1, 6'd11, 1'b1, 1'b0, 1'b0, 6'd9, 6'd0, 2'b01);
        tick();
        tick();
        n_total++;
        if (stall !== 1'b1) $display("FAIL mc_pending_only: got %b expected 1", stall);
        else n_pass++;
        mc_done = 1'b1; mc_rd = 6'd9;
        #1;
        n_total++;
        if (stall !== 1'b1) $display("FAIL mc_done_cycle: got %b expected 1", stall);
        else n_pass++;
        tick();
        mc_done = 1'b0; mc_rd = 6'd0;
        #1;
        n_total++;
        if (stall !== 1'b0 || fwd_sel !== 4'b0000)
            $display("FAIL mc_after_done: got sel=%b stall=%b expected 0000/0", fwd_sel, stall);
        else n_pass++;
        tick();
        drain();
    endtask

    task automatic test_youngest_hold;
        drive(1'b1, 6'd3, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00);
        tick();
        drive(1'b1, 6'd1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00);
        tick();
        drive(1'b1, 6'd3, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00);
        tick();
        drive(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 6'd1, 6'd3, 2'b11);
        n_total++;
        if (fwd_sel !== 4'b0110 || stall !== 1'b0)
            $display("FAIL young_sel: got sel=%b stall=%b expected 0110/0", fwd_sel, stall);
        else n_pass++;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (fwd_sel !== 4'b0110)
                $display("FAIL young_hold%0d: got %b expected 0110", i, fwd_sel);
            else n_pass++;
        end
        hold = 1'b0;
        tick();
        n_total++;
        if (fwd_sel !== 4'b1011)
            $display("FAIL young_release: got %b expected 1011", fwd_sel);
        else n_pass++;
        drain();
    endtask

    task automatic test_flush;
        drive(1'b1, 6'd9, 1'b1, 1'b0, 1'b1, 6'd0, 6'd0, 2'b00);
        tick();
        flush = 1'b1;
        drive(1'b1, 6'd11, 1'b1, 1'b0, 1'b0, 6'd9, 6'd0, 2'b01);
        n_total++;
        if (stall !== 1'b0) $display("FAIL flush_forces_stall0: got %b expected 0", stall);
        else n_pass++;
        tick();
        flush = 1'b0;
        #1;
        n_total++;
        if (stall !== 1'b0 || fwd_sel !== 4'b0000)
            $display("FAIL flush_reader: got sel=%b stall=%b expected 0000/0", fwd_sel, stall);
        else n_pass++;
        n_total++;
        if (dut.ent_q[1].valid !== 1'b0) $display("FAIL flush_entry: got %b expected 0", dut.ent_q[1].valid);
        else n_pass++;
        drive(1'b1, 6'd13, 1'b1, 1'b0, 1'b1, 6'd0, 6'd0, 2'b00);
        n_total++;
        if (stall !== 1'b0) $display("FAIL flush_bitmap: got %b expected 0", stall);
        else n_pass++;
        drain();
    endtask

    task automatic test_mid_reset;
        drive(1'b1, 6'd20, 1'b1, 1'b0, 1'b1, 6'd0, 6'd0, 2'b00);
        tick();
        drive(1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00);
        tick();
        drive(1'b1, 6'd6, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00);
        tick();
        drive(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 6'd5, 6'd6, 2'b11);
        n_total++;
        if (fwd_sel !== 4'b0110 || stall !== 1'b0)
            $display("FAIL prereset_sel: got sel=%b stall=%b expected 0110/0", fwd_sel, stall);
        else n_pass++;
        rst = 1'b1; hold = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; hold = 1'b0; flush = 1'b0;
        #1;
        n_total++;
        if (fwd_sel !== 4'b0000 || stall !== 1'b0)
            $display("FAIL postreset_sel: got sel=%b stall=%b expected 0000/0", fwd_sel, stall);
        else n_pass++;
        drive(1'b1, 6'd21, 1'b1, 1'b0, 1'b1, 6'd20, 6'd0, 2'b01);
        n_total++;
        if (stall !== 1'b0) $display("FAIL postreset_pending: got %b expected 0", stall);
        else n_pass++;
        idle();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_x0_unused();
        test_multicycle();
        test_youngest_hold();
        test_flush();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
